// File: rtl/axist_pkg.sv
// axist_pkg: shared FSM state type and packet-mode encodings for axist_pkt_src.
package axist_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  localparam int MODE_CUT = 0;
  localparam int MODE_SAF = 1;
endpackage

// File: rtl/axist_fifo.sv
// axist_fifo: word+last storage with registered level and power-of-two pointer wrap.
module axist_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      wr_last,
  input  logic                      rd,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_last,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign full = level == (AW+1)'(DEPTH);
  assign {rd_last, rd_data} = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      level <= level + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= {wr_last, wr_data};
endmodule

// File: rtl/axist_pkt_src.sv
// axist_pkt_src: FIFO-backed AXI-stream packet source, cut-through or store-and-forward.
// Define AXIST_PKT_SRC_STATS_EN to enable the sent-packet counter on pkt_cnt.
module axist_pkt_src import axist_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PKT_MODE = MODE_CUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      wr_last,
  output logic                      wr_full,
  input  logic                      ready,
  output logic                      valid,
  output logic                      last,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      ovf,
  output logic [15:0]               pkt_cnt
);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_nxt;
  logic [AW:0] npk;
  logic [DATA_WIDTH-1:0] q_data;
  logic q_last, wr_acc, rd_acc, start;
  assign wr_acc = wr_en & ~wr_full;
  assign valid = state == BURST && level != '0;
  assign rd_acc = valid & ready;
  assign dout = valid ? q_data : '0;
  assign last = valid & q_last;
  // a full FIFO with no complete packet must still drain, or it deadlocks
  assign start = PKT_MODE == MODE_SAF ? (npk != '0 || wr_full) : level != '0;
  axist_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .wr(wr_acc), .wr_data(wr_data), .wr_last(wr_last), .rd(rd_acc),
    .rd_data(q_data), .rd_last(q_last), .level(level), .full(wr_full)
  );
  always_comb
    state_nxt = state == IDLE ? (start ? BURST : IDLE) : (rd_acc && q_last ? IDLE : BURST);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      npk <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      npk <= npk + (AW+1)'(wr_acc & wr_last) - (AW+1)'(rd_acc & q_last);
      if (wr_en & wr_full) ovf <= 1'b1;
    end
`ifdef AXIST_PKT_SRC_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) pkt_cnt <= '0;
    else if (rd_acc & q_last) pkt_cnt <= pkt_cnt + 16'd1;
`else
  assign pkt_cnt = '0;
`endif
endmodule

// File: doc/axist_pkt_src.md
AXIST_PKT_SRC -- requirements
Module: axist_pkt_src

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the data bus width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, meaning the FIFO depth in words (power of 2, >=2).
REQ-003 SHALL have parameter PKT_MODE, default 0, meaning 0 = cut-through and 1 = store-and-forward.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: wr_en  in  1  write strobe.
REQ-007 SHALL have ports: wr_data  in  DATA_WIDTH  write word.
REQ-008 SHALL have ports: wr_last  in  1  write word ends a packet.
REQ-009 SHALL have ports: wr_full  out  1  FIFO holds DEPTH words.
REQ-010 SHALL have ports: ready  in  1  downstream AXI-stream tready.
REQ-011 SHALL have ports: valid  out  1  tvalid.
REQ-012 SHALL have ports: last  out  1  tlast.
REQ-013 SHALL have ports: dout  out  DATA_WIDTH  tdata.
REQ-014 SHALL have ports: level  out  $clog2(DEPTH)+1  words stored.
REQ-015 SHALL have ports: ovf  out  1  sticky overflow flag.
REQ-016 SHALL have ports: pkt_cnt  out  16  packets sent (see REQ-031).

Function
REQ-017 SHALL accept a word on every clk edge with wr_en=1 and wr_full=0; wr_full = (level==DEPTH), combinational from registered level.
REQ-018 SHALL drop wr_en while wr_full=1, even with a same-cycle read, and set ovf=1 until reset.
REQ-019 SHALL transfer a word on every edge with valid=1 and ready=1.
REQ-020 SHALL hold dout/last stable while valid=1 and ready=0, and never deassert valid before the handshake.
REQ-021 SHALL use output FSM states IDLE and BURST.
REQ-022 SHALL transition IDLE->BURST when start condition holds; PKT_MODE=0: level>0; PKT_MODE=1: complete-packet count>0 or wr_full=1 (oversize-packet deadlock escape).
REQ-023 SHALL, in BURST, assert valid whenever a word is available and return to IDLE on the handshake of a word with last=1.
REQ-024 SHALL make a word written at edge N visible on valid no earlier than edge N+1 (cut-through; first-word latency exactly 1 cycle from empty).
REQ-025 SHALL, in PKT_MODE=1, make the packet visible at edge N+1 where N writes wr_last.
REQ-026 SHALL update level by +1, -1 or 0 on simultaneous accepted write and read, with wrap-around of read and write pointers modulo DEPTH.
REQ-027 SHALL track complete packets with a counter of width $clog2(DEPTH)+1: increment on accepted wr_last, decrement on handshake of last, unchanged when both occur.
REQ-028 SHALL sustain a throughput of 1 word/cycle when ready=1 and the FIFO is non-empty.

Reset
REQ-029 SHALL, on rst=1, asynchronously force: valid=0, last=0, dout=0, level=0, ovf=0, pkt_cnt=0, wr_full=0, FSM=IDLE, pointers=0; FIFO contents undefined.
REQ-030 SHALL, on rst mid-packet, discard the partial packet, and the first word after release SHALL start a new packet.

Configuration
REQ-031 SHALL, with AXIST_PKT_SRC_STATS_EN defined, make pkt_cnt count handshakes of last=1, wrapping 16'hFFFF->0.
REQ-032 SHALL, without AXIST_PKT_SRC_STATS_EN, tie pkt_cnt to 0 and omit the counter logic; all other behaviour identical.

Structure
REQ-033 SHALL place the FSM state enum (IDLE, BURST) and the PKT_MODE encodings in package axist_pkg.
REQ-034 SHALL implement storage in sub-module axist_fifo (data+last per entry, level, pointer wrap); FSM and handshake in axist_pkt_src.

Verification
REQ-035 SHALL cover: PKT_MODE=0, write 8'h11,22,33 (last on 33), ready=1 -> valid from next cycle, dout 11,22,33 on 3 consecutive edges, last only with 33.
REQ-036 SHALL cover: ready toggled 1,0,0,1 mid-packet -> dout/last/valid held unchanged during ready=0, no word lost or duplicated.
REQ-037 SHALL cover: PKT_MODE=1, write 4 words with 3-cycle gaps -> valid=0 until cycle after word 4 (last), then 4 back-to-back words.
REQ-038 SHALL cover: DEPTH=4, ready=0, write 5 words -> wr_full=1 after 4th, 5th dropped, ovf=1, level=4; PKT_MODE=1 burst starts despite no last.
REQ-039 SHALL cover: rst asserted mid-packet with level=3 -> next cycle valid=0, level=0, ovf=0; new packet 8'hA0 (last) sent correctly after release.
REQ-040 SHALL cover: with AXIST_PKT_SRC_STATS_EN defined, send 3 packets -> pkt_cnt=3; without the macro, pkt_cnt=0.
